mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS five-stage pipeline. It sits beside the ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from ID_EX and computes products and quotients over multiple cycles. While a long operation is in flight, it raises a stall request that the hazard detection unit ORs into its PC, IF_ID and ID_EX stall outputs.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_unit_iter_step.sv | 32 +++
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states, iteration-step modes and a constant-width helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mdu_mode_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(parameter int XLEN = 32);
    import mdu_pkg::*;

    logic            valid_i;
    mdu_op_t         op_i;
    logic [XLEN-1:0] rs_data_i;
    logic [XLEN-1:0] rt_data_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, rs_data_i, rt_data_i, kill_i,
        input  busy_o, done_o, hi_o, lo_o, result_o
    );

    modport slave (
        input  valid_i, op_i, rs_data_i, rt_data_i, kill_i,
        output busy_o, done_o, hi_o, lo_o, result_o
    );

endinterface

// File: rtl/mul_div_unit_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on the {upper, lower} accumulator.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mdu_mode_t         mode_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   partial;
    logic [XLEN-1:0] trial;

    always_comb begin
        sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Remainder shifted left with the next dividend bit pulled in from below.
        partial = acc_i[2*XLEN-1:XLEN-1];
        trial   = partial[XLEN-1:0] - opnd_i;
        if (mode_i == MODE_MUL) begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end else if (partial >= {1'b0, opnd_i}) begin
            acc_o = {trial, acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {partial[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: works on operand magnitudes for
// XLEN cycles, then applies signs in a single FIX cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic  clk_i,
    input logic  rst_i,
    mdu_if.slave bus
);

    localparam int CW = clog2(XLEN);

    mdu_state_t        state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic              mulOp_q;
    logic              negRes_q;
    logic              negRem_q;
    logic              divZero_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              isSigned;
    logic              rsNeg;
    logic              rtNeg;
    logic [XLEN-1:0]   rsMag;
    logic [XLEN-1:0]   rtMag;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fixHi_d;
    logic [XLEN-1:0]   fixLo_d;
    logic [2*XLEN-1:0] accStep_d;
    mdu_mode_t         mode;

    always_comb begin
        accept   = bus.valid_i & ~busy_q & ~bus.kill_i;
        isSigned = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
        rsNeg    = isSigned & bus.rs_data_i[XLEN-1];
        rtNeg    = isSigned & bus.rt_data_i[XLEN-1];
        rsMag    = rsNeg ? -bus.rs_data_i : bus.rs_data_i;
        rtMag    = rtNeg ? -bus.rt_data_i : bus.rt_data_i;
        mode     = mulOp_q ? MODE_MUL : MODE_DIV;
        product  = negRes_q ? -acc_q : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        // Divide-by-zero keeps the all-ones quotient; the remainder already equals rs.
        if (mulOp_q) begin
            fixHi_d = product[2*XLEN-1:XLEN];
            fixLo_d = product[XLEN-1:0];
        end else begin
            fixHi_d = negRem_q ? -rem : rem;
            fixLo_d = (negRes_q & ~divZero_q) ? -quo : quo;
        end
    end

    mdu_iter_step #(.XLEN(XLEN)) u_step (
        .mode_i (mode),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (accStep_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            mulOp_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.kill_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.op_i)
                            OP_MULT, OP_MULTU: begin
                                state_q  <= ST_MUL;
                                busy_q   <= 1'b1;
                                cnt_q    <= '0;
                                acc_q    <= {{XLEN{1'b0}}, rtMag};
                                opnd_q   <= rsMag;
                                mulOp_q  <= 1'b1;
                                negRes_q <= rsNeg ^ rtNeg;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_q   <= ST_DIV;
                                busy_q    <= 1'b1;
                                cnt_q     <= '0;
                                acc_q     <= {{XLEN{1'b0}}, rsMag};
                                opnd_q    <= rtMag;
                                mulOp_q   <= 1'b0;
                                negRes_q  <= rsNeg ^ rtNeg;
                                negRem_q  <= rsNeg;
                                divZero_q <= (bus.rt_data_i == '0);
                            end
                            OP_MTHI: hi_q <= bus.rs_data_i;
                            OP_MTLO: lo_q <= bus.rs_data_i;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_q <= accStep_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_q <= ST_FIX;
                        cnt_q   <= '0;
                    end
                end
                ST_FIX: begin
                    hi_q    <= fixHi_d;
                    lo_q    <= fixLo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.hi_o     = hi_q;
    assign bus.lo_o     = lo_q;
    assign bus.result_o = (bus.op_i == OP_MFHI) ? hi_q :
                          (bus.op_i == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus random
// MULT/DIV traffic checked against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_if #(.XLEN(XLEN)) bus();

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [63:0] expQ[$];
    logic [31:0] refHi = '0;
    logic [31:0] refLo = '0;

    function automatic logic [63:0] refModel(input mdu_op_t op, input logic [31:0] rs,
                                             input logic [31:0] rt);
        longint      a;
        longint      b;
        logic [63:0] p;
        case (op)
            OP_MULT: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                p = 64'(a * b);
            end
            OP_MULTU: p = {32'b0, rs} * {32'b0, rt};
            OP_DIV: begin
                if (rt == 0) begin
                    p = {rs, 32'hFFFF_FFFF};
                end else begin
                    a = longint'($signed(rs));
                    b = longint'($signed(rt));
                    p = {32'(a % b), 32'(a / b)};
                end
            end
            OP_DIVU: begin
                if (rt == 0) p = {rs, 32'hFFFF_FFFF};
                else         p = {rs % rt, rs / rt};
            end
            default: p = {refHi, refLo};
        endcase
        return p;
    endfunction

    task automatic reportFail(input string name, input string msg);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) reportFail("busy timeout", "busy_o stayed high for 100 cycles");
    endtask

    task automatic applyStimulus(input mdu_op_t op, input logic [31:0] rs,
                                 input logic [31:0] rt, input bit expectDone);
        logic [63:0] e;
        waitIdle();
        bus.valid_i   = 1'b1;
        bus.op_i      = op;
        bus.rs_data_i = rs;
        bus.rt_data_i = rt;
        if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
            if (expectDone) begin
                e = refModel(op, rs, rt);
                expQ.push_back(e);
                refHi = e[63:32];
                refLo = e[31:0];
            end
        end else if (op == OP_MTHI) begin
            refHi = rs;
        end else if (op == OP_MTLO) begin
            refLo = rs;
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    task automatic runAndCheck(input mdu_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                               input string name, input logic [63:0] expected);
        applyStimulus(op, rs, rt, 1'b1);
        waitIdle();
        checkOutput(name, {bus.hi_o, bus.lo_o}, expected);
    endtask

    // Every done_o pulse must match the oldest outstanding MUL/DIV expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected done_o", "done_o pulsed with no operation outstanding");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("scoreboard hi/lo", {bus.hi_o, bus.lo_o}, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.valid_i   = 1'b0;
        bus.kill_i    = 1'b0;
        bus.op_i      = OP_MULT;
        bus.rs_data_i = '0;
        bus.rt_data_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy_o", 64'(bus.busy_o), 64'd0);
        checkOutput("reset done_o", 64'(bus.done_o), 64'd0);
        checkOutput("reset hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);
        checkOutput("reset result_o", 64'(bus.result_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency: busy for XLEN+1 cycles, done in the cycle busy drops.
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        n = 0;
        while (bus.busy_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("MULTU busy cycles", 64'(n), 64'd33);
        checkOutput("MULTU done at T0+34", 64'(bus.done_o), 64'd1);
        checkOutput("MULTU max", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);

        runAndCheck(OP_MULT, 32'hFFFF_FFFD, 32'd5, "MULT -3x5", 64'hFFFF_FFFF_FFFF_FFF1);
        runAndCheck(OP_DIV, 32'hFFFF_FFF9, 32'd2, "DIV -7/2", 64'hFFFF_FFFF_FFFF_FFFD);
        runAndCheck(OP_DIVU, 32'd10, 32'd0, "DIVU 10/0", 64'h0000_000A_FFFF_FFFF);
        runAndCheck(OP_DIV, 32'hFFFF_FFF9, 32'd0, "DIV -7/0", 64'hFFFF_FFF9_FFFF_FFFF);
        runAndCheck(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow", 64'h0000_0000_8000_0000);
        runAndCheck(OP_DIV, 32'd7, 32'hFFFF_FFFE, "DIV 7/-2", 64'h0000_0001_FFFF_FFFD);

        // Kill mid-MULT; a DIVU offered while busy must be ignored.
        applyStimulus(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b0);
        repeat (4) @(negedge clk);
        bus.valid_i   = 1'b1;
        bus.op_i      = OP_DIVU;
        bus.rs_data_i = 32'd100;
        bus.rt_data_i = 32'd3;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (4) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        checkOutput("kill busy_o low", 64'(bus.busy_o), 64'd0);
        checkOutput("kill keeps hi/lo", {bus.hi_o, bus.lo_o}, {refHi, refLo});
        repeat (40) @(negedge clk);
        checkOutput("kill stays idle", 64'(bus.busy_o), 64'd0);
        checkOutput("kill hi after wait", 64'(bus.hi_o), 64'h1234);

        // Kill in IDLE blocks an MTHI.
        bus.valid_i   = 1'b1;
        bus.kill_i    = 1'b1;
        bus.op_i      = OP_MTHI;
        bus.rs_data_i = 32'hDEAD;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.kill_i  = 1'b0;
        @(negedge clk);
        checkOutput("kill blocks MTHI", 64'(bus.hi_o), 64'h1234);

        // Synchronous reset mid-DIVU clears HI/LO and suppresses done_o.
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        refHi = '0;
        refLo = '0;
        checkOutput("rst busy_o", 64'(bus.busy_o), 64'd0);
        checkOutput("rst hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);
        repeat (40) @(negedge clk);

        // Back-to-back MFLO in the done cycle, then MTLO.
        applyStimulus(OP_MULTU, 32'd6, 32'd7, 1'b1);
        waitIdle();
        bus.op_i = OP_MFLO;
        #1;
        checkOutput("MFLO after MULTU", 64'(bus.result_o), 64'd42);
        bus.op_i = OP_MFHI;
        #1;
        checkOutput("MFHI after MULTU", 64'(bus.result_o), 64'd0);
        applyStimulus(OP_MTLO, 32'd5, 32'd0, 1'b0);
        checkOutput("MTLO visible", 64'(bus.lo_o), 64'd5);
        applyStimulus(OP_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0);
        checkOutput("MTHI visible", 64'(bus.hi_o), 64'hCAFE_F00D);

        for (int i = 0; i < 24; i++) begin
            mdu_op_t     op;
            logic [31:0] a;
            logic [31:0] b;
            op = mdu_op_t'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
            applyStimulus(op, a, b, 1'b1);
            if (i % 4 == 3) begin
                waitIdle();
                bus.op_i = OP_MFHI;
                #1;
                checkOutput("random MFHI", 64'(bus.result_o), 64'(refHi));
                bus.op_i = OP_MFLO;
                #1;
                checkOutput("random MFLO", 64'(bus.result_o), 64'(refLo));
            end
        end

        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
